// File: rtl/dht11_leitor.sv
// DHT11 single-wire reader: host start pulse, response handshake, 40-bit capture,
// checksum verification. All timing derives from an internal 1 us tick.
module dht11_leitor #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 100,
  parameter int BIT_THRESH_US = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  inout  wire        dht_data,
  output logic       busy,
  output logic       done,
  output logic       erro,
  output logic [1:0] erro_codigo,
  output logic [7:0] umid_int,
  output logic [7:0] umid_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  localparam int TICKS_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int TICK_W  = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int TICK_LD = (TICKS_PER_US > 1) ? 1 : 0;
  localparam int CNT_MAX = ((START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US) + BIT_THRESH_US + 2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, ERR
  } state_t;

  typedef struct packed {
    logic [7:0] umid_int;
    logic [7:0] umid_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
  } leitura_t;

  state_t      state, state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic [CNT_W-1:0]  us_cnt;
  logic        tick, state_chg;
  logic [2:0]  sync;
  logic        fall, rise;
  logic [39:0] frame;
  logic [5:0]  bit_idx;
  logic [1:0]  err_pend, err_nxt;
  logic        accept, shift_en, fin_ok, fin_err, timeout, bit_val;
  logic        drive_low;
  logic [7:0]  soma;
  leitura_t    leitura;

  // Open-drain: only ever pull low, the external pull-up supplies the '1'.
  assign dht_data = drive_low ? 1'b0 : 1'bz;

  assign {umid_int, umid_dec, temp_int, temp_dec} = leitura;

  // sync[2] is the previous synchronised sample, sync[1] the current one.
  assign fall = sync[2] & ~sync[1];
  assign rise = ~sync[2] & sync[1];

  always_ff @(posedge clock) begin
    if (reset) sync <= 3'b111;
    else       sync <= {sync[1:0], dht_data};
  end

  assign state_chg = (state_nxt != state);
  assign tick      = (tick_cnt == TICK_W'(TICKS_PER_US - 1));
  assign timeout   = (us_cnt == CNT_W'(TIMEOUT_US));
  assign bit_val   = (us_cnt > CNT_W'(BIT_THRESH_US));
  assign soma      = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];

  // The cycle in which a transition is decided counts as elapsed time, so the
  // prescaler restarts one step in; a W us pulse then measures exactly W.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
      us_cnt   <= '0;
    end else if (state_chg) begin
      tick_cnt <= TICK_W'(TICK_LD);
      us_cnt   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && us_cnt != '1) us_cnt <= us_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // An edge seen in the same cycle as the timeout is taken in preference.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_pend;
    accept    = 1'b0;
    shift_en  = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      IDLE:
        if (start && !busy) begin
          accept    = 1'b1;
          state_nxt = START_LOW;
        end
      START_LOW:
        if (us_cnt == CNT_W'(START_LOW_US)) state_nxt = WAIT_RESP;
      WAIT_RESP:
        if (fall)         state_nxt = RESP_LOW;
        else if (timeout) begin state_nxt = ERR; err_nxt = 2'd1; end
      RESP_LOW:
        if (rise)         state_nxt = RESP_HIGH;
        else if (timeout) begin state_nxt = ERR; err_nxt = 2'd1; end
      RESP_HIGH:
        if (fall)         state_nxt = BIT_LOW;
        else if (timeout) begin state_nxt = ERR; err_nxt = 2'd1; end
      BIT_LOW:
        if (rise)         state_nxt = BIT_HIGH;
        else if (timeout) begin state_nxt = ERR; err_nxt = 2'd2; end
      BIT_HIGH:
        if (fall) begin
          shift_en  = 1'b1;
          state_nxt = (bit_idx == 6'd39) ? CHECK : BIT_LOW;
        end else if (timeout) begin
          state_nxt = ERR;
          err_nxt   = 2'd2;
        end
      CHECK:
        if (soma == frame[7:0]) begin
          fin_ok    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = ERR;
          err_nxt   = 2'd3;
        end
      ERR: begin
        fin_err   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame    <= '0;
      bit_idx  <= '0;
      err_pend <= '0;
    end else begin
      err_pend <= err_nxt;
      if (accept) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        frame   <= {frame[38:0], bit_val};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Line drive is registered off the next state so it is glitch-free and
  // asserted for exactly the cycles spent in START_LOW.
  always_ff @(posedge clock) begin
    if (reset) drive_low <= 1'b0;
    else       drive_low <= (state_nxt == START_LOW);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      erro        <= 1'b0;
      erro_codigo <= '0;
      leitura     <= '0;
    end else begin
      done <= fin_ok | fin_err;
      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;
      if (accept) begin
        erro        <= 1'b0;
        erro_codigo <= '0;
      end else if (fin_err) begin
        erro        <= 1'b1;
        erro_codigo <= err_pend;
      end else if (fin_ok) begin
        erro        <= 1'b0;
        erro_codigo <= '0;
        leitura     <= frame[39:8];
      end
    end
  end

endmodule

// File: tb/tb_dht11_leitor.sv
// Bench for dht11_leitor: behavioural DHT11 sensor model, expected results queued
// at stimulus time and checked by a monitor on every done strobe.
module tb_dht11_leitor;

  localparam int US = 2;  // clock cycles per microsecond at CLK_FREQ_HZ = 2 MHz

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  wire        dht_data;
  logic       busy, done, erro;
  logic [1:0] erro_codigo;
  logic [7:0] umid_int, umid_dec, temp_int, temp_dec;

  logic sensor_low = 1'b0;
  int   sens_bit    = -1;
  bit   sens_active = 1'b0;

  pullup (dht_data);
  assign dht_data = sensor_low ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  dht11_leitor #(
    .CLK_FREQ_HZ  (2_000_000),
    .START_LOW_US (20),
    .TIMEOUT_US   (100),
    .BIT_THRESH_US(40)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dht_data   (dht_data),
    .busy       (busy),
    .done       (done),
    .erro       (erro),
    .erro_codigo(erro_codigo),
    .umid_int   (umid_int),
    .umid_dec   (umid_dec),
    .temp_int   (temp_int),
    .temp_dec   (temp_dec)
  );

  typedef struct {
    logic        erro;
    logic [1:0]  cod;
    logic [31:0] bytes;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  bit   busy_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (busy_chk) begin
      chk("busy_fall_after_done", {31'b0, busy}, 32'd0);
      busy_chk = 1'b0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      busy_chk = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_erro", {31'b0, erro}, {31'b0, e.erro});
        chk("done_codigo", {30'b0, erro_codigo}, {30'b0, e.cod});
        chk("done_bytes", {umid_int, umid_dec, temp_int, temp_dec}, e.bytes);
        chk("busy_at_done", {31'b0, busy}, 32'd1);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic push_exp(input logic e, input logic [1:0] c, input logic [31:0] b);
    exp_t x;
    x.erro = e; x.cod = c; x.bytes = b;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk(name, {31'b0, done_cnt >= target}, 32'd1);
  endtask

  task automatic wait_sensor_idle();
    int n = 0;
    while (sens_active && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("sensor_finished", {31'b0, sens_active}, 32'd0);
  endtask

  // Sensor: waits for the host start pulse, answers, then sends nbits bits MSB first.
  task automatic sensor_run(input logic [39:0] fr, input int nbits, input int hi0, input int hi1);
    int n;
    sens_active = 1'b1;
    n = 0;
    while (dht_data !== 1'b0 && n < 200 * US) begin @(negedge clock); n++; end
    chk("host_drives_low", {31'b0, dht_data === 1'b0}, 32'd1);
    n = 0;
    while (dht_data !== 1'b1 && n < 200 * US) begin @(negedge clock); n++; end
    chk("host_releases", {31'b0, dht_data === 1'b1}, 32'd1);
    repeat (20 * US) @(negedge clock);
    sensor_low = 1'b1; repeat (80 * US) @(negedge clock);
    sensor_low = 1'b0; repeat (80 * US) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      sensor_low = 1'b1; repeat (50 * US) @(negedge clock);
      sensor_low = 1'b0; sens_bit = i;
      repeat ((fr[39-i] ? hi1 : hi0) * US) @(negedge clock);
      sens_bit = -1;
    end
    if (nbits == 40) begin
      sensor_low = 1'b1; repeat (50 * US) @(negedge clock);
      sensor_low = 1'b0;
    end
    sens_active = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_erro", {29'b0, erro, erro_codigo}, 32'd0);
    chk("rst_bytes", {umid_int, umid_dec, temp_int, temp_dec}, 32'd0);
    chk("rst_line_released", {31'b0, dht_data === 1'b1}, 32'd1);

    // 1: good frame
    push_exp(1'b0, 2'd0, 32'h37001905);
    fork sensor_run(40'h3700190555, 40, 26, 70); join_none
    pulse_start();
    wait_done(1, "t1_done_seen");
    wait_sensor_idle();
    repeat (20) @(negedge clock);

    // 2: no sensor
    push_exp(1'b1, 2'd1, 32'h37001905);
    pulse_start();
    wait_done(2, "t2_done_seen");
    chk("t2_line_released", {31'b0, dht_data === 1'b1}, 32'd1);
    repeat (10) @(negedge clock);
    chk("t2_erro_holds", {29'b0, erro, erro_codigo}, {29'b0, 1'b1, 2'd1});

    // 3: sensor stops after 12 bits
    push_exp(1'b1, 2'd2, 32'h37001905);
    fork sensor_run(40'hFFF0000000, 12, 26, 70); join_none
    pulse_start();
    repeat (3) @(negedge clock);
    chk("t3_start_clears_erro", {29'b0, erro, erro_codigo}, 32'd0);
    wait_done(3, "t3_done_seen");
    wait_sensor_idle();
    repeat (20) @(negedge clock);

    // 4: checksum mismatch
    push_exp(1'b1, 2'd3, 32'h37001905);
    fork sensor_run(40'h3700190556, 40, 26, 70); join_none
    pulse_start();
    wait_done(4, "t4_done_seen");
    wait_sensor_idle();
    repeat (20) @(negedge clock);

    // 5: 40 us high -> 0, 41 us high -> 1; extra start while busy ignored
    push_exp(1'b0, 2'd0, 32'hA53C1281);
    fork sensor_run(40'hA53C128174, 40, 40, 41); join_none
    pulse_start();
    repeat (60) @(negedge clock);
    pulse_start();
    wait_done(5, "t5_done_seen");
    wait_sensor_idle();
    repeat (300) @(negedge clock);
    chk("t5_single_done", done_cnt, 32'd5);

    // 6: reset in BIT_HIGH
    fork sensor_run(40'hFF00000000, 40, 26, 70); join_none
    pulse_start();
    n = 0;
    while (sens_bit != 5 && n < 20000) begin @(negedge clock); n++; end
    chk("t6_reached_bit5", {31'b0, sens_bit == 5}, 32'd1);
    repeat (10 * US) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_busy_low", {31'b0, busy}, 32'd0);
    chk("t6_done_low", {31'b0, done}, 32'd0);
    chk("t6_line_released", {31'b0, dht_data === 1'b1}, 32'd1);
    reset = 1'b0;
    wait_sensor_idle();
    repeat (300) @(negedge clock);
    chk("t6_no_done", done_cnt, 32'd5);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
